// File: rtl/fadd_accum_pkg.sv
// Shared types, constants and operand classification for the fadd accumulator.
package fadd_accum_pkg;

    typedef enum logic [1:0] {IDLE, ACCEPT, ADD, DONE} state_e;

    typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_e;

    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

    // Exponent 0 is reported as zero, so denormals classify as zero.
    function automatic fp_class_e fp_classify(input logic [31:0] x);
        fp_class_e c;
        if (x[30:23] == 8'h00) begin
            c = FP_ZERO;
        end else if (x[30:23] == EXP_MAX) begin
            c = (x[22:0] == 23'h0) ? FP_INF : FP_NAN;
        end else begin
            c = FP_NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fadd.sv
// Combinational binary32 adder for normal operands, round-to-nearest-even.
module fadd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ovf
);

    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [26:0] m_big, m_sml, m_sh, nrm;
    logic        sticky, rnd_up;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic [24:0] m_rnd;

    always_comb begin
        if (b[30:0] > a[30:0]) begin
            big = b;
            sml = a;
        end else begin
            big = a;
            sml = b;
        end
        d     = big[30:23] - sml[30:23];
        m_big = {1'b1, big[22:0], 3'b000};
        m_sml = {1'b1, sml[22:0], 3'b000};
        if (d > 8'd26) begin
            m_sh   = '0;
            sticky = 1'b1;
        end else begin
            m_sh   = m_sml >> d;
            sticky = |(m_sml & ((27'd1 << d) - 27'd1));
        end
        m_sh[0] = m_sh[0] | sticky;

        if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_sh};
        else                    sum = {1'b0, m_big} - {1'b0, m_sh};

        e  = {2'b00, big[30:23]};
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else if ({5'b0, lz} >= e) begin
            nrm = '0;
            e   = '0;
        end else begin
            nrm = sum[26:0] << lz;
            e   = e - {5'b0, lz};
        end

        rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        m_rnd  = {1'b0, nrm[26:3]} + {24'b0, rnd_up};
        if (m_rnd[24]) e = e + 10'd1;

        ovf = (e >= 10'd255);
        if (ovf)             y = {big[31], 8'hFF, 23'b0};
        else if (e == 10'd0) y = {big[31], 31'b0};
        else                 y = {big[31], e[7:0], m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0]};
    end

endmodule

// File: rtl/fp_add_fixup.sv
// Resolves special operands and range errors around the raw adder result.
module fp_add_fixup
    import fadd_accum_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] core_y,
    output logic [31:0] y,
    output logic        ovf
);

    logic [31:0] af, bf;
    fp_class_e   ca, cb;
    logic [8:0]  ea, eb, er, emax;

    always_comb begin
        af   = (a[30:23] == 8'h00) ? {a[31], 31'b0} : a;
        bf   = (b[30:23] == 8'h00) ? {b[31], 31'b0} : b;
        ca   = fp_classify(af);
        cb   = fp_classify(bf);
        ea   = {1'b0, af[30:23]};
        eb   = {1'b0, bf[30:23]};
        er   = {1'b0, core_y[30:23]};
        emax = (ea > eb) ? ea : eb;
        y    = core_y;
        ovf  = 1'b0;

        if (ca == FP_NAN || cb == FP_NAN ||
            (ca == FP_INF && cb == FP_INF && af[31] != bf[31])) begin
            y = QNAN;
        end else if (ca == FP_INF) begin
            y = af;
        end else if (cb == FP_INF) begin
            y = bf;
        end else if (ca == FP_ZERO && cb == FP_ZERO) begin
            y = (af[31] && bf[31]) ? NEG_ZERO : POS_ZERO;
        end else if (ca == FP_ZERO) begin
            y = bf;
        end else if (cb == FP_ZERO) begin
            y = af;
        end else if (af[30:0] == bf[30:0] && af[31] != bf[31]) begin
            y = POS_ZERO;
        end else if (er == 9'h0FF || (emax == 9'h0FE && er < 9'h080)) begin
            // Second term catches a core whose exponent wrapped past 0xFF.
            y   = core_y[31] ? NEG_INF : POS_INF;
            ovf = 1'b1;
        end else if (er > emax + 9'd1 || er == 9'h000) begin
            y = POS_ZERO;
        end
    end

endmodule

// File: rtl/fadd_accumulator.sv
// Job-based binary32 sum: start/len command, operand stream, one result per job.
module fadd_accumulator
    import fadd_accum_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d, op_q, op_d, out_data_q, out_data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             out_ovf_q, out_ovf_d, busy_q, busy_d;
    logic [31:0]      core_y, fix_y;
    logic             fix_ovf, unused_core_ovf;

    fadd u_fadd (
        .a   (acc_q),
        .b   (op_q),
        .y   (core_y),
        .ovf (unused_core_ovf)
    );

    fp_add_fixup u_fixup (
        .a      (acc_q),
        .b      (op_q),
        .core_y (core_y),
        .y      (fix_y),
        .ovf    (fix_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = POS_ZERO;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    op_d    = in_data;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d   = fix_y;
                ovf_d   = ovf_q | fix_ovf;
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? DONE : ACCEPT;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == ACCEPT);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        out_data_d  = (state_d == DONE) ? acc_d : 32'h0;
        out_ovf_d   = (state_d == DONE) ? ovf_d : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'h0;
            op_q        <= 32'h0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;

endmodule

// File: doc/fadd_accumulator.md
Name: fadd_accumulator

Overview:
- Sequential reduction stage wrapped around the existing combinational single-precision `fadd` core.
- Accepts a start command with an element count, then a valid/ready stream of IEEE-754 binary32 operands, and sums them into a running accumulator.
- Returns one rounded sum per job over a valid/ready result port.
- Handles the cases the core does not: NaN/Inf, exact cancellation, denormal flush, exponent overflow/underflow.

Parameters:
- LEN_W, 16, width of the element-count input; jobs carry 0 to 2^LEN_W-1 elements.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  start pulse; sampled only in IDLE.
- len  input  LEN_W  number of elements in the job; latched with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  high only in ACCEPT.
- in_data  input  32  binary32 operand.
- out_valid  output  1  high only in DONE.
- out_ready  input  1  result consumer ready.
- out_data  output  32  accumulated binary32 sum.
- out_ovf  output  1  sticky: overflow occurred during the job.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, any state (including mid-job): state=IDLE; acc=32'h0; op_r=0; cnt=0; sticky flags=0; in_ready=0; out_valid=0; out_data=0; out_ovf=0; busy=0.
- States and transitions:
  - IDLE: on start, latch len into cnt and clear acc and sticky flags. cnt==0 goes to DONE, otherwise ACCEPT. start outside IDLE is ignored.
  - ACCEPT: in_ready=1. On in_valid&&in_ready, latch in_data into op_r and go to ADD.
  - ADD: the core sees a=acc, b=op_r, both registered. acc updates with the fixed-up result. cnt decrements; cnt reaching 0 goes to DONE, otherwise ACCEPT.
  - DONE: out_valid=1, out_data=acc, out_ovf=ovf_sticky. Both hold stable until out_ready, then go to IDLE.
- Throughput: 2 cycles per element.
- Latency: the last ADD cycle is followed by out_valid on the next cycle. A len=0 job shows out_valid 1 cycle after start is sampled.
- Fix-up rules, in priority order, evaluated in ADD on operands a (acc) and b (op_r):
  1. Denormal flush: an operand with exponent 0 is treated as a signed zero before any other rule.
  2. NaN: any NaN operand, or +Inf with -Inf, gives acc=QNAN (32'h7FC00000).
  3. Single infinity: one operand Inf (or both with the same sign) gives acc=that Inf.
  4. Zero operand: if one operand is ±0, acc=the other operand. ±0 + ±0 gives +0, except -0 + -0, which gives -0. The core is bypassed.
  5. Exact cancellation: same exponent and mantissa, opposite sign, gives acc=+0. The core is bypassed.
  6. Otherwise acc=core result, checked as follows:
     - Overflow: result exponent==8'hFF, or max(exp_a,exp_b)==8'hFE with result exponent <8'h80. Then acc=±Inf with the core result sign, and ovf_sticky is set.
     - Underflow: result exponent > max(exp_a,exp_b)+1, or result exponent==0. Then acc=+0.
- Once acc is NaN it stays NaN for the rest of the job.
- An ovf_sticky set by an earlier element persists even if a later element brings the value back to finite.
- The core's ovf output is not used.
- Width rules:
  - Exponent comparisons use 9-bit zero-extended values to avoid wrap.
  - cnt is LEN_W bits and never underflows: the decrement happens only in ADD with cnt>=1.

Decomposition:
- Package fadd_accum_pkg:
  - state enum: IDLE, ACCEPT, ADD, DONE.
  - constants: EXP_MAX=8'hFF, QNAN=32'h7FC00000, POS_INF=32'h7F800000, NEG_INF=32'hFF800000, POS_ZERO=32'h0.
  - a function returning the class of a binary32 operand: zero, normal, inf, nan.
- One sub-module fp_add_fixup:
  - Combinational; takes a, b and the core result.
  - Outputs the fixed-up value and an ovf flag (rules 1-6).
- The top holds the FSM, registers and the `fadd` instance.

Test Plan:
- len=3; inputs 3F800000, 40000000, 40400000; out_ready=1 -> out_data=40C00000, out_ovf=0, out_valid 7 cycles after start.
- len=0 start -> out_valid next cycle, out_data=00000000, in_ready never asserted.
- len=2; inputs 3F800000, BF800000 -> out_data=00000000 (cancellation path).
- len=2; inputs 7F7FFFFF, 7F7FFFFF -> out_data=7F800000, out_ovf=1.
- len=3; inputs 7F800000, FF800000, 3F800000 -> out_data=7FC00000 (NaN persists).
- len=2 with in_valid gaps of 3 cycles, out_ready low for 5 cycles, then rst pulse during a second job's ACCEPT:
  - out_data holds stable while out_ready is low.
  - After rst: all outputs 0 and state IDLE immediately, and the next job of 40000000+40000000 gives 40800000.
